step_tracker: RTL and testbench

Passive monitor on the stepper driver's STEP/DIR/nHOME/nFAULT lines. It sits beside the stepper pulse generator, taps the same nets, and reconstructs the carriage state for the scan controller:
- signed absolute position in microsteps,
- measured step period,
- motion status,
- home-index capture,
- latched driver fault.

It has no outputs toward the motor.

---
 rtl/stepper_pkg.sv | 16 +
 rtl/sync_edge.sv | 42 ++++
 rtl/step_tracker.sv | 181 ++++++++++++++++++
 tb/tb_step_tracker.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared constants and types for the stepper motor lines.
// Imported by the step tracker and the future motion controller.
package stepper_pkg;

  localparam int unsigned POS_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 1_000_000;

  typedef logic signed [POS_W_DEF-1:0] pos_t;

  // Idle (inactive) levels of the driver lines
  localparam logic STEP_IDLE  = 1'b0;
  localparam logic DIR_IDLE   = 1'b0;
  localparam logic NHOME_IDLE = 1'b1;
  localparam logic NFLT_IDLE  = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses aligned to the synchronized level.
// RST_LVL should be the line's idle level so that reset release never produces an edge.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_LVL = 1'b0
) (
  input  logic clk_100M,
  input  logic nrst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Edges are taken from the last two stages so the pulse lines up with q changing
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
  end

  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      sync_q <= {STAGES{RST_LVL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/step_tracker.sv
// Passive monitor of STEP/DIR/nHOME/nFAULT: reconstructs position, step period,
// motion status, home capture and a sticky driver fault for the scan controller.
module step_tracker
  import stepper_pkg::*;
#(
  parameter int unsigned POS_W       = POS_W_DEF,
  parameter int unsigned PER_W       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk_100M,
  input  logic             nrst,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             nhome_in,
  input  logic             nflt_in,
  input  logic             zero_on_home,
  input  logic             clr,
  output logic [POS_W-1:0] position,
  output logic             pos_valid,
  output logic [PER_W-1:0] step_period,
  output logic             period_valid,
  output logic             moving,
  output logic             home_seen,
  output logic [POS_W-1:0] home_pos,
  output logic             fault,
  output logic             fault_latched
);

  localparam logic [PER_W-1:0] PER_MAX     = {PER_W{1'b1}};
  localparam logic [PER_W-1:0] TIMEOUT_CNT = PER_W'(TIMEOUT - 1);

  logic step_s, step_rise, step_fall;
  logic dir_s, dir_rise, dir_fall;
  logic nhome_s, nhome_rise, nhome_fall;
  logic nflt_s, nflt_rise, nflt_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(STEP_IDLE)) u_sync_step (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d_in     (step_in),
    .q        (step_s),
    .rise     (step_rise),
    .fall     (step_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(DIR_IDLE)) u_sync_dir (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d_in     (dir_in),
    .q        (dir_s),
    .rise     (dir_rise),
    .fall     (dir_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(NHOME_IDLE)) u_sync_nhome (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d_in     (nhome_in),
    .q        (nhome_s),
    .rise     (nhome_rise),
    .fall     (nhome_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(NFLT_IDLE)) u_sync_nflt (
    .clk_100M (clk_100M),
    .nrst     (nrst),
    .d_in     (nflt_in),
    .q        (nflt_s),
    .rise     (nflt_rise),
    .fall     (nflt_fall)
  );

  assign unused_sync = ^{step_s, step_fall, dir_rise, dir_fall, nhome_s, nhome_rise,
                         nflt_rise, nflt_fall};

  logic [POS_W-1:0] position_q, position_d, pos_after;
  logic             pos_valid_q, pos_valid_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d, per_cnt_inc;
  logic [PER_W-1:0] step_period_q, step_period_d;
  logic             period_valid_q, period_valid_d;
  logic             ref_valid_q, ref_valid_d;
  logic             moving_q, moving_d;
  logic             home_seen_q, home_seen_d;
  logic [POS_W-1:0] home_pos_q, home_pos_d;
  logic             fault_latched_q, fault_latched_d;
  logic             fault_s;

  assign fault_s = ~nflt_s;

  always_comb begin
    pos_after = position_q;
    if (step_rise) begin
      pos_after = dir_s ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end
    per_cnt_inc = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_W'(1);

    position_d     = pos_after;
    pos_valid_d    = step_rise;
    home_seen_d    = home_seen_q;
    home_pos_d     = home_pos_q;
    per_cnt_d      = per_cnt_inc;
    step_period_d  = step_period_q;
    period_valid_d = 1'b0;
    ref_valid_d    = ref_valid_q;
    moving_d       = moving_q;

    // home_pos sees the same-cycle step even when zeroing discards it
    if (nhome_fall) begin
      home_pos_d  = pos_after;
      home_seen_d = 1'b1;
      if (zero_on_home) begin
        position_d = '0;
      end
    end

    if (step_rise) begin
      step_period_d  = per_cnt_inc;
      per_cnt_d      = '0;
      period_valid_d = ref_valid_q;
      ref_valid_d    = 1'b1;
      moving_d       = 1'b1;
    end else if (per_cnt_q == TIMEOUT_CNT) begin
      moving_d    = 1'b0;
      ref_valid_d = 1'b0;
    end

    if (clr) begin
      position_d     = '0;
      pos_valid_d    = 1'b0;
      home_seen_d    = 1'b0;
      home_pos_d     = '0;
      per_cnt_d      = '0;
      step_period_d  = step_period_q;
      period_valid_d = 1'b0;
      ref_valid_d    = 1'b0;
      moving_d       = 1'b0;
    end

    // An active fault overrides clr
    fault_latched_d = fault_s | (fault_latched_q & ~clr);
  end

  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      position_q      <= '0;
      pos_valid_q     <= 1'b0;
      per_cnt_q       <= '0;
      step_period_q   <= '0;
      period_valid_q  <= 1'b0;
      ref_valid_q     <= 1'b0;
      moving_q        <= 1'b0;
      home_seen_q     <= 1'b0;
      home_pos_q      <= '0;
      fault_latched_q <= 1'b0;
    end else begin
      position_q      <= position_d;
      pos_valid_q     <= pos_valid_d;
      per_cnt_q       <= per_cnt_d;
      step_period_q   <= step_period_d;
      period_valid_q  <= period_valid_d;
      ref_valid_q     <= ref_valid_d;
      moving_q        <= moving_d;
      home_seen_q     <= home_seen_d;
      home_pos_q      <= home_pos_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign position      = position_q;
  assign pos_valid     = pos_valid_q;
  assign step_period   = step_period_q;
  assign period_valid  = period_valid_q;
  assign moving        = moving_q;
  assign home_seen     = home_seen_q;
  assign home_pos      = home_pos_q;
  assign fault         = fault_s;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker: vector table for step/home/clear sequences plus
// hand-written checks for latency, period, timeout, same-cycle events, fault and reset.
module tb_step_tracker;

  localparam int unsigned TO = 5000;

  logic        clk_100M = 1'b0;
  logic        nrst = 1'b0;
  logic        step_in = 1'b0;
  logic        dir_in = 1'b0;
  logic        nhome_in = 1'b1;
  logic        nflt_in = 1'b1;
  logic        zero_on_home = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] position, home_pos;
  logic [23:0] step_period;
  logic        pos_valid, period_valid, moving, home_seen, fault, fault_latched;

  int n_checks = 0;
  int n_errors = 0;
  int pv_cnt = 0;
  int pd_cnt = 0;
  int per_bad = 0;
  logic chk_per = 1'b0;

  step_tracker #(
    .POS_W       (32),
    .PER_W       (24),
    .SYNC_STAGES (2),
    .TIMEOUT     (TO)
  ) dut (
    .clk_100M      (clk_100M),
    .nrst          (nrst),
    .step_in       (step_in),
    .dir_in        (dir_in),
    .nhome_in      (nhome_in),
    .nflt_in       (nflt_in),
    .zero_on_home  (zero_on_home),
    .clr           (clr),
    .position      (position),
    .pos_valid     (pos_valid),
    .step_period   (step_period),
    .period_valid  (period_valid),
    .moving        (moving),
    .home_seen     (home_seen),
    .home_pos      (home_pos),
    .fault         (fault),
    .fault_latched (fault_latched)
  );

  always #5 clk_100M = ~clk_100M;

  always @(negedge clk_100M) begin
    if (pos_valid) pv_cnt++;
    if (period_valid) pd_cnt++;
    if (period_valid && chk_per && step_period != 24'd4002) per_bad++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_100M);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_steps(input logic d, input int n);
    dir_in = d;
    tick(4);
    repeat (n) begin
      step_in = 1'b1;
      tick(4);
      step_in = 1'b0;
      tick(4);
    end
    tick(2);
  endtask

  task automatic do_home(input logic z);
    zero_on_home = z;
    nhome_in = 1'b0;
    tick(6);
    nhome_in = 1'b1;
    tick(6);
    zero_on_home = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " position"}, position, 0);
    check({tag, " pos_valid"}, pos_valid, 0);
    check({tag, " step_period"}, step_period, 0);
    check({tag, " period_valid"}, period_valid, 0);
    check({tag, " moving"}, moving, 0);
    check({tag, " home_seen"}, home_seen, 0);
    check({tag, " home_pos"}, home_pos, 0);
    check({tag, " fault"}, fault, 0);
    check({tag, " fault_latched"}, fault_latched, 0);
  endtask

  localparam int OP_CLR = 0;
  localparam int OP_STEP = 1;
  localparam int OP_HOME = 2;

  typedef struct {
    int          op;
    logic        d;
    int          n;
    logic        z;
    logic [31:0] pos;
    logic        hs;
    logic [31:0] hp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int pv0, pd0, k, fcnt;

    tbl[0]  = '{OP_CLR,  1'b0, 0,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{OP_STEP, 1'b0, 5,  1'b0, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000};
    tbl[2]  = '{OP_STEP, 1'b1, 5,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[3]  = '{OP_STEP, 1'b1, 37, 1'b0, 32'h0000_0025, 1'b0, 32'h0000_0000};
    tbl[4]  = '{OP_HOME, 1'b0, 0,  1'b1, 32'h0000_0000, 1'b1, 32'h0000_0025};
    tbl[5]  = '{OP_STEP, 1'b1, 3,  1'b0, 32'h0000_0003, 1'b1, 32'h0000_0025};
    tbl[6]  = '{OP_HOME, 1'b0, 0,  1'b0, 32'h0000_0003, 1'b1, 32'h0000_0003};
    tbl[7]  = '{OP_STEP, 1'b1, 2,  1'b0, 32'h0000_0005, 1'b1, 32'h0000_0003};
    tbl[8]  = '{OP_STEP, 1'b0, 7,  1'b0, 32'hFFFF_FFFE, 1'b1, 32'h0000_0003};
    tbl[9]  = '{OP_HOME, 1'b0, 0,  1'b0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE};
    tbl[10] = '{OP_CLR,  1'b0, 0,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};

    // Reset state
    tick(3);
    check_all_zero("in_reset");
    nrst = 1'b1;
    tick(4);
    check_all_zero("after_reset");

    // Ten steps 4002 cycles apart, with latency and pulse-width checks on the first
    dir_in = 1'b1;
    tick(4);
    pv0 = pv_cnt;
    pd0 = pd_cnt;
    chk_per = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_in = 1'b1;
      for (int c = 1; c <= 4002; c++) begin
        tick(1);
        if (c == 10) step_in = 1'b0;
        if (i == 0 && c == 2) check("latency pos_before", position, 0);
        if (i == 0 && c == 3) begin
          check("latency pos_after", position, 1);
          check("latency pos_valid", pos_valid, 1);
        end
        if (i == 0 && c == 4) check("pos_valid width", pos_valid, 0);
      end
    end
    chk_per = 1'b0;
    check("run10 position", position, 10);
    check("run10 pos_valid count", pv_cnt - pv0, 10);
    check("run10 period_valid count", pd_cnt - pd0, 9);
    check("run10 bad periods", per_bad, 0);
    check("run10 step_period", step_period, 4002);
    check("run10 moving", moving, 1);

    // Vector table of step / home / clear operations
    for (int i = 0; i < 11; i++) begin
      case (tbl[i].op)
        OP_CLR:  pulse_clr();
        OP_STEP: do_steps(tbl[i].d, tbl[i].n);
        default: do_home(tbl[i].z);
      endcase
      check($sformatf("vec%0d position", i), position, tbl[i].pos);
      check($sformatf("vec%0d home_seen", i), home_seen, tbl[i].hs);
      check($sformatf("vec%0d home_pos", i), home_pos, tbl[i].hp);
    end

    // Home and step detected in the same cycle, zero_on_home=1
    do_steps(1'b1, 36);
    check("combo pre position", position, 36);
    zero_on_home = 1'b1;
    step_in = 1'b1;
    nhome_in = 1'b0;
    tick(3);
    check("combo position", position, 0);
    check("combo home_pos", home_pos, 37);
    check("combo home_seen", home_seen, 1);
    check("combo pos_valid", pos_valid, 1);
    tick(3);
    step_in = 1'b0;
    nhome_in = 1'b1;
    zero_on_home = 1'b0;
    tick(6);

    // Same again with clr in the detect cycle; clr wins and step_period holds
    do_steps(1'b1, 36);
    check("combo_clr pre position", position, 36);
    zero_on_home = 1'b1;
    step_in = 1'b1;
    nhome_in = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("combo_clr position", position, 0);
    check("combo_clr home_seen", home_seen, 0);
    check("combo_clr home_pos", home_pos, 0);
    check("combo_clr pos_valid", pos_valid, 0);
    check("combo_clr step_period held", step_period, 8);
    tick(3);
    step_in = 1'b0;
    nhome_in = 1'b1;
    zero_on_home = 1'b0;
    tick(6);

    // Timeout: moving high for exactly TO cycles, then reference edge invalid
    pd0 = pd_cnt;
    step_in = 1'b1;
    tick(3);
    check("timeout moving set", moving, 1);
    k = 0;
    while (moving && k < int'(TO) + 20) begin
      tick(1);
      k++;
    end
    check("timeout moving cycles", k, TO);
    check("first edge after clr period_valid", pd_cnt - pd0, 0);
    step_in = 1'b0;
    tick(4);
    pd0 = pd_cnt;
    step_in = 1'b1;
    tick(50);
    step_in = 1'b0;
    tick(50);
    check("edge after timeout period_valid", pd_cnt - pd0, 0);
    step_in = 1'b1;
    tick(5);
    check("second edge period_valid", pd_cnt - pd0, 1);
    check("second edge step_period", step_period, 100);
    step_in = 1'b0;
    tick(4);

    // Fault: low for 3 cycles
    fcnt = 0;
    nflt_in = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      if (t == 3) nflt_in = 1'b1;
      if (fault) fcnt++;
      if (t == 1) check("fault latency early", fault, 0);
      if (t == 2) begin
        check("fault latency", fault, 1);
        check("fault_latched latency early", fault_latched, 0);
      end
      if (t == 3) check("fault_latched latency", fault_latched, 1);
    end
    check("fault high cycles", fcnt, 3);
    check("fault released", fault, 0);
    check("fault_latched sticky", fault_latched, 1);
    nflt_in = 1'b0;
    tick(4);
    pulse_clr();
    check("clr during fault", fault_latched, 1);
    nflt_in = 1'b1;
    tick(4);
    check("fault_latched after release", fault_latched, 1);
    pulse_clr();
    check("clr after fault", fault_latched, 0);

    // Asynchronous reset mid-stream
    do_steps(1'b1, 3);
    do_home(1'b0);
    nflt_in = 1'b0;
    tick(4);
    check("pre_reset fault_latched", fault_latched, 1);
    check("pre_reset home_seen", home_seen, 1);
    #2;
    nrst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    nflt_in = 1'b1;
    tick(3);
    nrst = 1'b1;
    tick(4);
    check("post_reset position", position, 0);
    check("post_reset home_seen", home_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
